// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multicycle RV32 core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects and write enables.
module multicycle_control_fsm #(
    parameter int CNT_W = 32,
    parameter int FSM_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             adr_src,
    output logic [1:0]       imm_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem_write,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_count,
    output logic [FSM_W-1:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q;
    logic             retire;
    logic             op_legal;

    logic       irw, pcw, rgw, mw;

    assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                      (op == OP_I)  || (op == OP_JAL) || (op == OP_BEQ);

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ:       state_d = BEQ;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            JAL:      state_d = ALUWB;
            BEQ:      state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
                    ((state_q == MEMWRITE) && mem_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire)
                instr_count_q <= instr_count_q + CNT_W'(1);
        end
    end

    // Moore decode of the current state; only enables look at mem_ready/zero.
    always_comb begin
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        irw        = 1'b0;
        pcw        = 1'b0;
        rgw        = 1'b0;
        mw         = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                irw        = mem_ready;
                pcw        = mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                rgw        = 1'b1;
            end
            MEMWRITE: begin
                adr_src = 1'b1;
                mw      = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            ALUWB:    rgw = 1'b1;
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pcw       = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pcw       = zero;
            end
            default: ;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    assign ir_write      = irw & ~rst;
    assign pc_write      = pcw & ~rst;
    assign reg_write     = rgw & ~rst;
    assign mem_write     = mw & ~rst;
    assign illegal_instr = (state_q == DECODE) & ~op_legal & ~rst;
    assign instr_count   = instr_count_q;
    assign state_dbg     = FSM_W'(state_q);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction state/output sequences are built
// from the instruction class and handshake waits, then checked cycle by cycle.
module tb_multicycle_control_fsm;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                   S_MEMWRITE = 5, S_EXECR = 6, S_ALUWB = 7, S_EXECI = 8, S_JAL = 9, S_BEQ = 10;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  op = 7'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src, imm_src;
    logic        adr_src, ir_write, pc_write, reg_write, mem_write, illegal_instr;
    logic [31:0] instr_count;
    logic [3:0]  state_dbg;

    logic [1:0]  a2, b2, ao2, rs2, im2;
    logic        ad2, irw2, pcw2, rw2, mw2, ill2;
    logic [1:0]  cnt2;
    logic [3:0]  st2;

    int errors = 0;
    int checks = 0;
    int cnt = 0;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .adr_src(adr_src), .imm_src(imm_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .mem_write(mem_write), .illegal_instr(illegal_instr),
        .instr_count(instr_count), .state_dbg(state_dbg)
    );

    // Narrow counter instance exercises wrap-around after a handful of retirements.
    multicycle_control_fsm #(.CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .alu_src_a(a2), .alu_src_b(b2), .alu_op(ao2),
        .result_src(rs2), .adr_src(ad2), .imm_src(im2),
        .ir_write(irw2), .pc_write(pcw2), .reg_write(rw2),
        .mem_write(mw2), .illegal_instr(ill2),
        .instr_count(cnt2), .state_dbg(st2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JL) || (o == BQ);
    endfunction

    // {alu_src_a, alu_src_b, alu_op, result_src, adr_src, ir_write, pc_write, reg_write, mem_write}
    function automatic logic [12:0] exp_out(input int st, input logic mr, input logic z, input logic r);
        logic [1:0] a, b, ao, rs;
        logic ad, irw, pcw, rw, mw;
        {a, b, ao, rs, ad, irw, pcw, rw, mw} = '0;
        if (st == S_FETCH)    begin b = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end
        if (st == S_DECODE)   begin a = 2'b01; b = 2'b01; end
        if (st == S_MEMADR)   begin a = 2'b10; b = 2'b01; end
        if (st == S_MEMREAD)  ad = 1'b1;
        if (st == S_MEMWB)    begin rs = 2'b01; rw = 1'b1; end
        if (st == S_MEMWRITE) begin ad = 1'b1; mw = 1'b1; end
        if (st == S_EXECR)    begin a = 2'b10; ao = 2'b10; end
        if (st == S_EXECI)    begin a = 2'b10; b = 2'b01; ao = 2'b10; end
        if (st == S_ALUWB)    rw = 1'b1;
        if (st == S_JAL)      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
        if (st == S_BEQ)      begin a = 2'b10; ao = 2'b01; pcw = z; end
        if (r) {irw, pcw, rw, mw} = 4'b0000;
        return {a, b, ao, rs, ad, irw, pcw, rw, mw};
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == SW) return 2'b01;
        if (o == BQ) return 2'b10;
        if (o == JL) return 2'b11;
        return 2'b00;
    endfunction

    task automatic check_now(input int st);
        chk("state", state_dbg, st);
        chk("outs", {alu_src_a, alu_src_b, alu_op, result_src, adr_src, ir_write, pc_write,
                     reg_write, mem_write}, exp_out(st, mem_ready, zero, rst));
        chk("imm_src", imm_src, exp_imm(op));
        chk("illegal", illegal_instr, (st == S_DECODE) && !is_legal(op) && !rst);
        chk("count", instr_count, cnt);
        chk("count_w", cnt2, cnt % 4);
        chk("state_w", st2, st);
    endtask

    task automatic do_cycle(input int st, input logic mr, input logic z);
        mem_ready = mr;
        zero = z;
        @(negedge clk);
        check_now(st);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] o, input int fw, input int mw, input logic z);
        int q_st[$];
        logic q_mr[$];
        bit retires;
        op = o;
        for (int i = 0; i < fw; i++) begin q_st.push_back(S_FETCH); q_mr.push_back(1'b0); end
        q_st.push_back(S_FETCH); q_mr.push_back(1'b1);
        q_st.push_back(S_DECODE); q_mr.push_back(1'($urandom));
        retires = 1'b1;
        if (o == LW || o == SW) begin
            q_st.push_back(S_MEMADR); q_mr.push_back(1'($urandom));
            for (int i = 0; i < mw; i++) begin
                q_st.push_back(o == LW ? S_MEMREAD : S_MEMWRITE); q_mr.push_back(1'b0);
            end
            q_st.push_back(o == LW ? S_MEMREAD : S_MEMWRITE); q_mr.push_back(1'b1);
            if (o == LW) begin q_st.push_back(S_MEMWB); q_mr.push_back(1'($urandom)); end
        end else if (o == RT || o == IT || o == JL) begin
            q_st.push_back(o == RT ? S_EXECR : (o == IT ? S_EXECI : S_JAL));
            q_mr.push_back(1'($urandom));
            q_st.push_back(S_ALUWB); q_mr.push_back(1'($urandom));
        end else if (o == BQ) begin
            q_st.push_back(S_BEQ); q_mr.push_back(1'($urandom));
        end else begin
            retires = 1'b0;
        end
        foreach (q_st[i])
            do_cycle(q_st[i], q_mr[i], (q_st[i] == S_BEQ) ? z : 1'($urandom));
        if (retires) cnt++;
    endtask

    initial begin
        logic [6:0] rop;
        logic [6:0] ops[6];
        ops = '{LW, SW, RT, IT, JL, BQ};

        mem_ready = 1'b1;
        #12;
        check_now(S_FETCH);
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr(RT, 0, 0, 1'b0);
        run_instr(LW, 3, 2, 1'b0);
        run_instr(SW, 0, 0, 1'b0);
        run_instr(BQ, 0, 0, 1'b1);
        run_instr(BQ, 0, 0, 1'b0);
        run_instr(7'b1111111, 0, 0, 1'b0);
        run_instr(JL, 1, 0, 1'b0);
        run_instr(IT, 0, 0, 1'b0);
        run_instr(SW, 1, 2, 1'b0);

        // Abandon a load mid-MEMREAD with an asynchronous reset pulse.
        op = LW;
        do_cycle(S_FETCH, 1'b1, 1'b0);
        do_cycle(S_DECODE, 1'b1, 1'b0);
        do_cycle(S_MEMADR, 1'b1, 1'b0);
        mem_ready = 1'b0;
        #1;
        check_now(S_MEMREAD);
        mem_ready = 1'b1;
        rst = 1'b1;
        cnt = 0;
        #1;
        check_now(S_FETCH);
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr(RT, 0, 0, 1'b0);
        run_instr(RT, 0, 0, 1'b0);
        run_instr(RT, 0, 0, 1'b0);
        chk("count_w_max", cnt2, 2'b11);
        run_instr(JL, 0, 0, 1'b0);
        chk("count_w_wrap", cnt2, 2'b00);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                do rop = 7'($urandom); while (is_legal(rop));
            end else begin
                rop = ops[$urandom_range(0, 5)];
            end
            run_instr(rop, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control sequencer for the multicycle RV32 core. Walks each instruction through fetch / decode / execute / memory / writeback states. Drives the shared-ALU operand selects, the alu_op code consumed by the existing ALU decoder, and all register/memory/PC write enables. Stalls on a memory ready handshake and keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter
FSM_W, 4, state register width (fixed encoding below)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-high reset
op  in  7  instr[6:0] from instruction register
zero  in  1  ALU zero flag (combinational, current cycle)
mem_ready  in  1  memory handshake: access completes this cycle when 1
alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1 data
alu_src_b  out  2  00=rs2 data, 01=imm, 10=const 4
alu_op  out  2  00 add, 01 sub, 10 funct-decoded (to ALU decoder)
result_src  out  2  00=ALUOut, 01=read data, 10=ALU result
adr_src  out  1  0=PC, 1=ALUOut
imm_src  out  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
ir_write  out  1  instruction register load enable
pc_write  out  1  PC load enable
reg_write  out  1  register file write enable
mem_write  out  1  data memory write enable
illegal_instr  out  1  one-cycle pulse on unsupported opcode
instr_count  out  CNT_W  retired-instruction counter
state_dbg  out  FSM_W  current state, for debug/bench

Behaviour:
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Codes 11-15 unreachable; if entered, next state is FETCH.
- Reset (async, rst=1): state=FETCH, instr_count=0. While rst=1 all write enables (ir_write, pc_write, reg_write, mem_write) and illegal_instr are forced 0. Mux/selects take FETCH values. Reset mid-instruction abandons it with no count increment.
- Outputs are Moore decodes of state. Exceptions: write enables gated by mem_ready / zero as stated below. Unlisted selects are 00/0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write=pc_write=mem_ready. Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precompute). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - other -> FETCH, with illegal_instr=1 for this cycle and no count increment.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Holds while mem_ready=0, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Next is FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Holds while mem_ready=0; mem_write stays high while holding. Next is FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Next is ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Next is ALUWB.
- ALUWB: result_src=00, reg_write=1. Next is FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Next is ALUWB.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero. Next is FETCH.
- imm_src: pure combinational from op (independent of state).
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else -> 00
- instr_count: +1 on each transition into FETCH from MEMWB, MEMWRITE (when mem_ready=1), ALUWB or BEQ. Wraps modulo 2^CNT_W.
- Cycle counts with mem_ready held at 1: lw 5, sw 4, R/I 4, jal 4, beq 3.

Test Plan:
- Reset mid-MEMREAD (assert rst for 1 cycle) -> state_dbg=0 immediately (async); all write enables 0 while rst=1; instr_count=0.
- R-type op=0110011, mem_ready=1 -> state sequence 0,1,6,7,0. alu_op=10 in EXECUTER; reg_write=1 only in ALUWB; instr_count +1.
- lw op=0000011, mem_ready=0 for 3 cycles in FETCH and 2 cycles in MEMREAD -> FETCH held 4 cycles, ir_write pulses only on the ready cycle. Sequence 0,1,2,3,4,0; total 10 cycles.
- sw op=0100011 -> 0,1,2,5,0. mem_write=1 and adr_src=1 in MEMWRITE; imm_src=01; reg_write never 1.
- beq op=1100011: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0. Both cases return to FETCH after 3 cycles; alu_op=01.
- Illegal op=1111111 -> DECODE then FETCH, illegal_instr one-cycle pulse, instr_count unchanged. Separately preset count to 2^CNT_W-1 and retire one jal -> count=0.
